// File: rtl/gcd_engine.sv
// gcd_engine: handshaked binary (Stein) GCD, one operation at a time.
// Returns gcd, a both-operands-zero flag and the CALC cycle count.
module gcd_engine #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(2*WIDTH+2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_cycles
);

  localparam int K_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      k          <= '0;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_gcd    <= '0;
      out_zero   <= 1'b0;
      out_cycles <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a        <= in_a;
            b        <= in_b;
            k        <= '0;
            cnt      <= '0;
            out_zero <= (in_a == '0) && (in_b == '0);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt_inc;
          // rule order guarantees the odd-odd subtraction never underflows
          if (a == '0) begin
            out_gcd    <= b << k;
            out_cycles <= cnt_inc;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (b == '0) begin
            out_gcd    <= a << k;
            out_cycles <= cnt_inc;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + K_W'(1);
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a >= b) begin
            a <= (a - b) >> 1;
          end else begin
            b <= (b - a) >> 1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed and random checks of gcd_engine (WIDTH=8)
// against a plain-arithmetic reference model.
module tb_gcd_engine;

  localparam int W  = 8;
  localparam int CW = $clog2(2*W+2);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_gcd;
  logic          out_zero;
  logic [CW-1:0] out_cycles;

  int n_cmp;
  int n_err;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  gcd_engine #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gcd    (out_gcd),
    .out_zero   (out_zero),
    .out_cycles (out_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Euclid by remainder gives the value; the Stein rules give the cycle count
  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int ref_cycles(input int x, input int y);
    int n;
    n = 0;
    while (1) begin
      n++;
      if (x == 0 || y == 0) break;
      if (x % 2 == 0 && y % 2 == 0) begin
        x = x / 2;
        y = y / 2;
      end else if (x % 2 == 0) x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x >= y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
    return n;
  endfunction

  // accept one pair, scramble the inputs, wait for out_valid; lat = edges
  task automatic start_op(input int a, input int b, output int lat);
    int t;
    in_a = W'(a);
    in_b = W'(b);
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      tick;
      t++;
    end
    tick;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick;
      lat++;
    end
    if (lat >= 100) chk("timeout", 32'(lat), 32'd0);
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("ready_after_hs", 32'(in_ready), 32'd1);
    chk("valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  task automatic directed(input int a, input int b, input int g,
                          input int n, input int z);
    int lat;
    start_op(a, b, lat);
    chk($sformatf("gcd(%0d,%0d)", a, b), 32'(out_gcd), 32'(g));
    chk($sformatf("cyc(%0d,%0d)", a, b), 32'(out_cycles), 32'(n));
    chk($sformatf("zero(%0d,%0d)", a, b), 32'(out_zero), 32'(z));
    chk($sformatf("lat(%0d,%0d)", a, b), 32'(lat), 32'(n));
    finish_op;
  endtask

  // stream the queued pairs; rnd randomizes out_ready, else gaps are checked
  task automatic stream(input bit rnd);
    int cnt, sent, got, cyc, last_acc, last_n, n;
    bit acc, ret;
    cnt = qa.size();
    sent = 0;
    got = 0;
    cyc = 0;
    last_acc = -1;
    last_n = 0;
    while (got < cnt && cyc < 60 * cnt + 100) begin
      in_valid = (sent < cnt);
      if (sent < cnt) begin
        in_a = qa[sent];
        in_b = qb[sent];
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        n = ref_cycles(int'(qa[got]), int'(qb[got]));
        chk("s_gcd", 32'(out_gcd), 32'(ref_gcd(int'(qa[got]), int'(qb[got]))));
        chk("s_zero", 32'(out_zero), 32'(qa[got] == 0 && qb[got] == 0));
        chk("s_cyc", 32'(out_cycles), 32'(n));
        chk("s_cyc_bound", 32'(out_cycles <= 17), 32'd1);
        got++;
      end
      if (acc) begin
        if (!rnd && last_acc >= 0)
          chk("s_gap", 32'(cyc - last_acc), 32'(last_n + 2));
        last_acc = cyc;
        last_n = ref_cycles(int'(qa[sent]), int'(qb[sent]));
        sent++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("s_sent", 32'(sent), 32'(cnt));
    chk("s_got", 32'(got), 32'(cnt));
  endtask

  initial begin
    int lat, hg, hc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_gcd", 32'(out_gcd), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    chk("rst_cycles", 32'(out_cycles), 32'd0);
    rst = 1'b0;

    directed(12, 18, 6, 5, 0);
    directed(0, 0, 0, 1, 1);
    directed(0, 5, 5, 1, 0);
    directed(7, 7, 7, 2, 0);
    directed(40, 0, 40, 1, 0);
    directed(1, 255, 1, 9, 0);
    directed(128, 192, 64, 10, 0);

    // back-pressure with a competing input request
    start_op(12, 18, lat);
    hg = int'(out_gcd);
    hc = int'(out_cycles);
    in_valid = 1'b1;
    in_a = 8'd9;
    in_b = 8'd3;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_gcd", 32'(out_gcd), 32'(hg));
      chk("hold_cyc", 32'(out_cycles), 32'(hc));
    end
    in_valid = 1'b0;
    finish_op;
    tick;
    chk("hold_no_accept", 32'(in_ready), 32'd1);

    // reset two cycles into CALC
    in_a = 8'd1;
    in_b = 8'd255;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    tick;
    rst = 1'b0;
    hg = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (out_valid) hg = 1;
    end
    chk("mid_rst_no_valid", 32'(hg), 32'd0);
    directed(12, 18, 6, 5, 0);

    // back-to-back with out_ready held high
    qa = '{8'd12, 8'd1, 8'd0, 8'd128};
    qb = '{8'd18, 8'd255, 8'd0, 8'd192};
    stream(1'b0);

    // random pairs with random back-pressure
    qa.delete();
    qb.delete();
    for (int i = 0; i < 1500; i++) begin
      qa.push_back(($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom));
      qb.push_back(($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom));
    end
    stream(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
